seqdiv: RTL and testbench
=========================

# seqdiv

Sequential restoring divider: the inverse companion of the team's sequential shift-add multiplier. Divides an unsigned N-bit dividend by an unsigned D-bit divisor, one quotient bit per clock, MSB first. It has the same `load`/`ready_out` handshake style as the multiplier, so both can sit behind the same small datapath controller. It adds explicit divide-by-zero reporting.

## Interface
- `NW`, 8: dividend and quotient width.
- `DW`, 4: divisor and remainder width; `DW <= NW`.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_a` in 1: reset; synchronous, active-high.
- `n` in NW: dividend, sampled only on an accepted load.
- `d` in DW: divisor, sampled only on an accepted load.
- `load` in 1: start request.
- `q` out NW: quotient.
- `r` out DW: remainder.
- `ready_out` out 1: result valid.
- `busy` out 1: division in progress.
- `div_zero` out 1: last accepted operation had `d == 0`.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE; `q`, `r`, `ready_out`, `busy`, `div_zero` all 0; step counter 0.
- **Accepted load:** `load == 1` while in IDLE or DONE. On that edge:
  - capture `n` and `d`;
  - clear `ready_out`, clear `div_zero`;
  - clear the internal partial remainder (DW+1 bits) and the counter.
- After a load with `d != 0`: next state RUN, `busy = 1`.
- After a load with `d == 0`: next state DONE. Set `q = {NW{1}}`, `r = {DW{1}}`, `div_zero = 1`, `ready_out = 1`, `busy = 0`.
- **RUN step** (one per edge):
  - `p = {rem[DW-1:0], nsh[NW-1]}`, DW+1 bits;
  - if `p >= {0,d}`: `rem = p - d`, shift 1 into the quotient shift register;
  - else: `rem = p`, shift 0;
  - `nsh` shifts left by 1; counter increments.
- **RUN exit:** when the counter reaches NW-1 and that step completes:
  - `q` is loaded from the quotient shift register;
  - `r` is loaded from `rem[DW-1:0]`;
  - `ready_out = 1`, `busy = 0`, state DONE.
- `q` and `r` hold the previous result for the whole of RUN. They change only on the DONE-entry edge.
- DONE: outputs hold until the next accepted load or reset.
- `load` during RUN is ignored. There is no queuing and no restart.
- Remainder is always < `d`, so it fits in DW bits; the extra bit exists only for the compare.
- Reset asserted mid-RUN aborts the operation: the next cycle shows reset values, and the partial result is discarded.
- `rst_a` and `load` asserted on the same edge: reset wins.

## Timing
- Latency for `d != 0`: `ready_out` rises NW+1 edges after the load edge (9 for defaults).
  - Load edge: IDLE→RUN.
  - NW step edges; the last step also updates `q`/`r` and enters DONE.
- Latency for `d == 0`: `ready_out` is high after the load edge itself (1 edge).
- Throughput: one division per NW+1 cycles, back-to-back. A load held high in DONE restarts immediately.
- `ready_out`, `busy`, `q`, `r` and `div_zero` are all registered; there are no combinational paths from inputs to outputs.
- `busy` and `ready_out` are never both 1.

## Structure
- Package `seqdiv_pkg` holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default widths NW_DEF=8, DW_DEF=4.
- Sub-module `div_step`: purely combinational, one restoring step. Inputs `rem`, `nbit`, `d`; outputs `rem_next`, `qbit`. It is reused by a future unrolled divider.
- Top: FSM, counter of width $clog2(NW), shift registers, output registers.

## Test plan
- Reset, then load `n=200`, `d=7` → after 9 edges `q=28`, `r=4`, `ready_out=1`, `div_zero=0`; `busy` is high for exactly 8 cycles.
- Load `255/1`, then `13/15`, then `0/5`, back-to-back with `load` held → `q/r` = 255/0, then 0/13, then 0/0, each 9 edges apart.
- Load `100/0` → one edge later `q=8'hFF`, `r=4'hF`, `div_zero=1`, `ready_out=1`. A following load of `100/10` clears `div_zero` and gives `q=10`, `r=0`.
- Pulse `load` with `60/4` at RUN step 3, while `120/11` is in progress → ignored; the result is `q=10`, `r=10`.
- Assert `rst_a` at RUN step 5 → next cycle all outputs 0 and state IDLE. A new load of `9/3` then gives `q=3`, `r=0`.
- Exhaustive sweep over all `n` in 0..255 and `d` in 1..15, against `n/d` and `n%d` → no mismatches, and `ready_out` always at edge 9.

Source files
------------

// File: rtl/seqdiv_pkg.sv
// seqdiv_pkg: shared definitions for the sequential restoring divider.
//   - state_t    : FSM encoding (IDLE, RUN, DONE)
//   - NW_DEF/DW_DEF : default dividend/divisor widths
//   - cnt_w()    : step-counter width for a given dividend width
package seqdiv_pkg;

    localparam int NW_DEF = 8;
    localparam int DW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // At least one bit, so a 1-bit dividend still gets a legal counter.
    function automatic int cnt_w(input int nw);
        return (nw > 1) ? $clog2(nw) : 1;
    endfunction

endpackage

// File: rtl/seqdiv_if.sv
// seqdiv_if: load/ready handshake bundle for the divider.
//   master (controller): drives n, d, load; observes the result outputs
//   slave  (divider)   : observes n, d, load; drives q, r, ready_out, busy, div_zero
interface seqdiv_if
    import seqdiv_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
);
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    logic          load;
    logic [NW-1:0] q;
    logic [DW-1:0] r;
    logic          ready_out;
    logic          busy;
    logic          div_zero;

    modport master (
        output n, d, load,
        input  q, r, ready_out, busy, div_zero
    );

    modport slave (
        input  n, d, load,
        output q, r, ready_out, busy, div_zero
    );
endinterface

// File: rtl/seqdiv_div_step.sv
// div_step: one combinational restoring-division step.
//   i_rem      : current partial remainder (DW+1 bits, top bit unused on input)
//   i_nbit     : next dividend bit shifted in
//   i_d        : divisor
//   o_rem_next : partial remainder after this step
//   o_qbit     : quotient bit produced by this step
module div_step
    import seqdiv_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW:0]   i_rem,
    input  logic          i_nbit,
    input  logic [DW-1:0] i_d,
    output logic [DW:0]   o_rem_next,
    output logic          o_qbit
);
    logic [DW:0] w_p;
    logic [DW:0] w_dext;

    // The remainder is always < d, so its low DW bits carry all the
    // information; the extra bit only keeps the shifted value comparable.
    assign w_p        = {i_rem[DW-1:0], i_nbit};
    assign w_dext     = {1'b0, i_d};
    assign o_qbit     = (w_p >= w_dext);
    assign o_rem_next = o_qbit ? (w_p - w_dext) : w_p;
endmodule

// File: rtl/seqdiv.sv
// seqdiv: sequential restoring divider, one quotient bit per clock, MSB first.
//   i_clk    : clock, rising edge
//   i_rst_a  : synchronous active-high reset
//   io_div   : seqdiv_if.slave -- n/d/load in; q/r/ready_out/busy/div_zero out
// A load accepted in IDLE or DONE starts a new division; load during RUN is
// ignored. Divide-by-zero completes on the load edge with all-ones results.
module seqdiv
    import seqdiv_pkg::*;
#(
    parameter int NW = NW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic   i_clk,
    input  logic   i_rst_a,
    seqdiv_if.slave io_div
);
    localparam int              CW       = cnt_w(NW);
    localparam logic [CW-1:0]   CNT_LAST = CW'(NW - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          w_accept;
    logic          w_last;
    logic          w_dzero;

    logic [NW-1:0] r_nsh;
    logic [DW-1:0] r_d;
    logic [DW:0]   r_rem;
    logic [NW-1:0] r_qsh;
    logic [CW-1:0] r_cnt;

    logic [NW-1:0] r_q;
    logic [DW-1:0] r_r;
    logic          r_ready;
    logic          r_busy;
    logic          r_dz;

    logic [DW:0]   w_rem_next;
    logic          w_qbit;
    logic [NW-1:0] w_qsh_next;

    div_step #(.DW(DW)) u_step (
        .i_rem      (r_rem),
        .i_nbit     (r_nsh[NW-1]),
        .i_d        (r_d),
        .o_rem_next (w_rem_next),
        .o_qbit     (w_qbit)
    );

    // Quotient including the bit from the current step, so the final step
    // can publish the complete result on the same edge.
    assign w_qsh_next = {r_qsh[NW-2:0], w_qbit};
    assign w_dzero    = (io_div.d == '0);

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst_a) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    // FSM next state / control
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (io_div.load) begin
                    w_accept     = 1'b1;
                    w_state_next = w_dzero ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst_a) begin
            r_nsh   <= '0;
            r_d     <= '0;
            r_rem   <= '0;
            r_qsh   <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_dz    <= 1'b0;
        end else if (w_accept) begin
            r_nsh   <= io_div.n;
            r_d     <= io_div.d;
            r_rem   <= '0;
            r_qsh   <= '0;
            r_cnt   <= '0;
            r_ready <= w_dzero;
            r_dz    <= w_dzero;
            r_busy  <= ~w_dzero;
            // A normal load keeps the previous q/r visible through RUN.
            if (w_dzero) begin
                r_q <= '1;
                r_r <= '1;
            end
        end else if (r_state == RUN) begin
            r_rem <= w_rem_next;
            r_qsh <= w_qsh_next;
            r_nsh <= {r_nsh[NW-2:0], 1'b0};
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_q     <= w_qsh_next;
                r_r     <= w_rem_next[DW-1:0];
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign io_div.q         = r_q;
    assign io_div.r         = r_r;
    assign io_div.ready_out = r_ready;
    assign io_div.busy      = r_busy;
    assign io_div.div_zero  = r_dz;
endmodule

// File: tb/tb_seqdiv.sv
// tb_seqdiv: directed, table-driven bench for seqdiv (NW=8, DW=4), with
// hand-written sequences for back-to-back loads, ignored loads, reset
// mid-run and an exhaustive n/d sweep.
module tb_seqdiv;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] prev_q;
    logic [3:0] prev_r;

    typedef struct {
        logic [7:0] n;
        logic [3:0] d;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } vec_t;

    vec_t tbl [12];

    seqdiv_if #(.NW(8), .DW(4)) bus ();

    seqdiv #(.NW(8), .DW(4)) dut (
        .i_clk   (clk),
        .i_rst_a (rst),
        .io_div  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".q"},     32'(bus.q), 0);
        chk({tag, ".r"},     32'(bus.r), 0);
        chk({tag, ".ready"}, 32'(bus.ready_out), 0);
        chk({tag, ".busy"},  32'(bus.busy), 0);
        chk({tag, ".dz"},    32'(bus.div_zero), 0);
    endtask

    // One load, then count edges to ready_out; q must hold its previous
    // value while busy, and busy must last NW cycles for a nonzero divisor.
    task automatic run_op(input string tag, input logic [7:0] n, input logic [3:0] d,
                          input logic [7:0] eq, input logic [3:0] er, input logic edz);
        int edges;
        int bcnt;
        int holdbad;
        bus.n    = n;
        bus.d    = d;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        edges   = 1;
        bcnt    = 0;
        holdbad = 0;
        while (!bus.ready_out && edges < 20) begin
            if (bus.busy) bcnt++;
            if (bus.q !== prev_q || bus.r !== prev_r) holdbad++;
            tick();
            edges++;
        end
        chk({tag, ".lat"},   32'(edges), (d == 0) ? 1 : 9);
        chk({tag, ".q"},     32'(bus.q), 32'(eq));
        chk({tag, ".r"},     32'(bus.r), 32'(er));
        chk({tag, ".dz"},    32'(bus.div_zero), 32'(edz));
        chk({tag, ".busy"},  32'(bus.busy), 0);
        chk({tag, ".bcnt"},  32'(bcnt), (d == 0) ? 0 : 8);
        chk({tag, ".hold"},  32'(holdbad), 0);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        logic [7:0] bb_n [3];
        logic [3:0] bb_d [3];
        logic [7:0] bb_q [3];
        logic [3:0] bb_r [3];

        checks   = 0;
        failures = 0;
        prev_q   = '0;
        prev_r   = '0;

        tbl[0]  = '{8'd200, 4'd7,  8'd28,  4'd4,  1'b0};
        tbl[1]  = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0};
        tbl[2]  = '{8'd13,  4'd15, 8'd0,   4'd13, 1'b0};
        tbl[3]  = '{8'd0,   4'd5,  8'd0,   4'd0,  1'b0};
        tbl[4]  = '{8'd100, 4'd0,  8'hFF,  4'hF,  1'b1};
        tbl[5]  = '{8'd100, 4'd10, 8'd10,  4'd0,  1'b0};
        tbl[6]  = '{8'd120, 4'd11, 8'd10,  4'd10, 1'b0};
        tbl[7]  = '{8'd9,   4'd3,  8'd3,   4'd0,  1'b0};
        tbl[8]  = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0};
        tbl[9]  = '{8'd1,   4'd15, 8'd0,   4'd1,  1'b0};
        tbl[10] = '{8'd254, 4'd13, 8'd19,  4'd7,  1'b0};
        tbl[11] = '{8'd0,   4'd0,  8'hFF,  4'hF,  1'b1};

        bb_n = '{8'd255, 8'd13, 8'd0};
        bb_d = '{4'd1,   4'd15, 4'd5};
        bb_q = '{8'd255, 8'd0,  8'd0};
        bb_r = '{4'd0,   4'd13, 4'd0};

        // Reset state
        rst      = 1'b1;
        bus.load = 1'b0;
        bus.n    = '0;
        bus.d    = '0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Directed table
        for (int i = 0; i < 12; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].dz);

        // Load pulse during RUN is ignored: 120/11 keeps running
        bus.n = 8'd120; bus.d = 4'd11; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (2) tick();
        bus.n = 8'd60; bus.d = 4'd4; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        chk("ign.busy", 32'(bus.busy), 1);
        repeat (4) tick();
        chk("ign.ready8", 32'(bus.ready_out), 0);
        tick();
        chk("ign.ready9", 32'(bus.ready_out), 1);
        chk("ign.q", 32'(bus.q), 10);
        chk("ign.r", 32'(bus.r), 10);
        prev_q = 8'd10;
        prev_r = 4'd10;

        // Reset mid-RUN discards the partial result
        bus.n = 8'd200; bus.d = 4'd7; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("midrst");
        prev_q = '0;
        prev_r = '0;
        run_op("after_rst", 8'd9, 4'd3, 8'd3, 4'd0, 1'b0);

        // Reset and load on the same edge: reset wins, no division starts
        bus.n = 8'd50; bus.d = 4'd5; bus.load = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; bus.load = 1'b0;
        chk_reset_vals("rstload");
        tick();
        chk("rstload.busy2", 32'(bus.busy), 0);
        prev_q = '0;
        prev_r = '0;

        // Back-to-back with load held high: a new division every 9 edges
        bus.n = bb_n[0]; bus.d = bb_d[0]; bus.load = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k < 2) begin
                bus.n = bb_n[k+1];
                bus.d = bb_d[k+1];
            end
            repeat (7) tick();
            chk($sformatf("b2b%0d.ready8", k), 32'(bus.ready_out), 0);
            tick();
            chk($sformatf("b2b%0d.ready9", k), 32'(bus.ready_out), 1);
            chk($sformatf("b2b%0d.q", k), 32'(bus.q), 32'(bb_q[k]));
            chk($sformatf("b2b%0d.r", k), 32'(bus.r), 32'(bb_r[k]));
        end
        bus.load = 1'b0;
        prev_q = bb_q[2];
        prev_r = bb_r[2];
        tick();

        // Exhaustive sweep against the arithmetic model
        for (int nn = 0; nn < 256; nn++) begin
            for (int dd = 1; dd < 16; dd++) begin
                run_op($sformatf("sw%0d_%0d", nn, dd), 8'(nn), 4'(dd),
                       8'(nn / dd), 4'(nn % dd), 1'b0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
